// File: rtl/simon_core_param.sv
// simon_core_param
//   Parametrised Simon game datapath/controller. The player enters a
//   WIDTH-bit switch pattern, which is appended to a DEPTH-entry sequence
//   memory. The full sequence is then played back, and the player must
//   repeat it from the switches. Repeating a full DEPTH-long sequence
//   reaches the WIN state.
//
// Ports
//   sysclk        in   system clock, rising edge
//   rst           in   synchronous, active-high reset
//   level         in   difficulty select, captured while rst is high
//   press         in   raw step button level (rising edge detected here)
//   pattern       in   WIDTH-bit switch inputs
//   pattern_leds  out  switches (INPUT/REPEAT) or mem[idx] (other states)
//   mode_leds     out  INPUT=001 PLAYBACK=010 REPEAT=100 DONE=111 WIN=011
//   score         out  number of fully repeated rounds (saturates at DEPTH)
module simon_core_param #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              level,
  input  logic              press,
  input  logic [WIDTH-1:0]  pattern,
  output logic [WIDTH-1:0]  pattern_leds,
  output logic [2:0]        mode_leds,
  output logic [ADDR_W:0]   score
);

  localparam logic [2:0] S_INPUT = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_REP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;

  localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   SCORE_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // lvl=0 accepts exactly one switch set; lvl=1 accepts any nonzero pattern.
  function automatic logic pattern_valid(input logic [WIDTH-1:0] p,
                                         input logic             hard);
    logic nonzero;
    logic onehot;
    nonzero = (p != '0);
    onehot  = nonzero && ((p & (p - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    return hard ? nonzero : onehot;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   score_q, score_d;
  logic              first_q, first_d;
  logic              lvl_q;
  logic              press_q;
  logic              ev;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data;

  // Button edge detector; press_q tracks the raw level even during reset so
  // that a button held across reset release does not create an event.
  always_ff @(posedge sysclk) begin
    press_q <= press;
  end

  assign ev      = press & ~press_q & ~rst;
  assign rd_data = mem_q[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    score_d = score_q;
    first_d = first_q;
    we      = 1'b0;
    waddr   = first_q ? '0 : cnt_q + IDX_ONE;
    if (ev) begin
      case (state_q)
        S_INPUT: begin
          if (pattern_valid(pattern, lvl_q)) begin
            we      = 1'b1;
            cnt_d   = waddr;
            idx_d   = '0;
            first_d = 1'b0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (idx_q == cnt_q) begin
            idx_d   = '0;
            state_d = S_REP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
        S_REP: begin
          if (pattern != rd_data) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else if (idx_q != cnt_q) begin
            idx_d = idx_q + IDX_ONE;
          end else begin
            score_d = score_q + SCORE_ONE;
            idx_d   = '0;
            // A full memory repeated correctly cannot grow further.
            state_d = (cnt_q == IDX_LAST) ? S_WIN : S_INPUT;
          end
        end
        S_DONE, S_WIN: begin
          idx_d = (idx_q == cnt_q) ? '0 : idx_q + IDX_ONE;
        end
        default: begin
          state_d = S_INPUT;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Control registers: reset takes priority over any event.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_INPUT;
      cnt_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      first_q <= 1'b1;
      lvl_q   <= level;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      first_q <= first_d;
    end
  end

  // Sequence memory keeps its contents across reset.
  always_ff @(posedge sysclk) begin
    if (we && !rst) begin
      mem_q[waddr] <= pattern;
    end
  end

  always_comb begin
    mode_leds    = 3'b001;
    pattern_leds = pattern;
    case (state_q)
      S_INPUT: begin
        mode_leds    = 3'b001;
        pattern_leds = pattern;
      end
      S_PLAY: begin
        mode_leds    = 3'b010;
        pattern_leds = rd_data;
      end
      S_REP: begin
        mode_leds    = 3'b100;
        pattern_leds = pattern;
      end
      S_DONE: begin
        mode_leds    = 3'b111;
        pattern_leds = rd_data;
      end
      S_WIN: begin
        mode_leds    = 3'b011;
        pattern_leds = rd_data;
      end
      default: begin
        mode_leds    = 3'b001;
        pattern_leds = pattern;
      end
    endcase
  end

  assign score = score_q;

endmodule

// File: tb/tb_simon_core_param.sv
// Testbench for simon_core_param, built with DEPTH=4 so that the WIN state
// is reachable with a short sequence.
module tb_simon_core_param;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  localparam logic [2:0] M_IN   = 3'b001;
  localparam logic [2:0] M_PLAY = 3'b010;
  localparam logic [2:0] M_REP  = 3'b100;
  localparam logic [2:0] M_DONE = 3'b111;
  localparam logic [2:0] M_WIN  = 3'b011;

  logic              sysclk = 1'b0;
  logic              rst    = 1'b1;
  logic              level  = 1'b0;
  logic              press  = 1'b0;
  logic [WIDTH-1:0]  pattern = '0;
  logic [WIDTH-1:0]  pattern_leds;
  logic [2:0]        mode_leds;
  logic [ADDR_W:0]   score;

  typedef struct {
    string            tag;
    logic [2:0]       mode;
    logic [WIDTH-1:0] leds;
    logic [ADDR_W:0]  score;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] seq [DEPTH];
  int               seq_len;
  logic [ADDR_W:0]  exp_score;

  simon_core_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .level        (level),
    .press        (press),
    .pattern      (pattern),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds),
    .score        (score)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] m,
                          input logic [WIDTH-1:0] l, input logic [ADDR_W:0] s);
    exp_t e;
    e.tag   = tag;
    e.mode  = m;
    e.leds  = l;
    e.score = s;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      total++;
      assert (mode_leds === e.mode) else begin
        bad++;
        $error("FAIL %s mode got=%b exp=%b", e.tag, mode_leds, e.mode);
      end
      total++;
      assert (pattern_leds === e.leds) else begin
        bad++;
        $error("FAIL %s leds got=%b exp=%b", e.tag, pattern_leds, e.leds);
      end
      total++;
      assert (score === e.score) else begin
        bad++;
        $error("FAIL %s score got=%0d exp=%0d", e.tag, score, e.score);
      end
    end
  endtask

  // Expectation is queued when the press is driven and checked once the
  // press has been taken and released.
  task automatic press_exp(input string tag, input logic [WIDTH-1:0] pat,
                           input logic [2:0] m, input logic [WIDTH-1:0] l,
                           input logic [ADDR_W:0] s);
    push_exp(tag, m, l, s);
    pattern = pat;
    press   = 1'b1;
    tick();
    press   = 1'b0;
    tick();
    pop_check();
  endtask

  task automatic do_reset(input logic lv);
    rst   = 1'b1;
    level = lv;
    tick();
    rst   = 1'b0;
    exp_score = '0;
    seq_len   = 0;
  endtask

  // One full round: add p, step through playback, repeat the whole sequence.
  task automatic do_round(input string tag, input logic [WIDTH-1:0] p);
    logic [2:0]       end_mode;
    logic [WIDTH-1:0] end_leds;
    seq[seq_len] = p;
    seq_len++;
    press_exp({tag, "_enter"}, p, M_PLAY, seq[0], exp_score);
    for (int i = 1; i < seq_len; i++)
      press_exp({tag, "_play"}, p, M_PLAY, seq[i], exp_score);
    press_exp({tag, "_to_rep"}, 4'b0000, M_REP, 4'b0000, exp_score);
    for (int i = 0; i < seq_len; i++) begin
      if (i < seq_len - 1) begin
        press_exp({tag, "_rep"}, seq[i], M_REP, seq[i], exp_score);
      end else begin
        exp_score = exp_score + 1'b1;
        end_mode  = (seq_len == DEPTH) ? M_WIN : M_IN;
        end_leds  = (seq_len == DEPTH) ? seq[0] : seq[i];
        press_exp({tag, "_rep_last"}, seq[i], end_mode, end_leds, exp_score);
      end
    end
  endtask

  initial begin
    // 1: reset state and level-0 validity
    pattern = 4'b1010;
    do_reset(1'b0);
    push_exp("reset_state", M_IN, 4'b1010, 0);
    pop_check();
    press_exp("lvl0_invalid", 4'b1010, M_IN, 4'b1010, 0);
    level = 1'b1;
    press_exp("lvl_not_resampled", 4'b1010, M_IN, 4'b1010, 0);
    press_exp("lvl0_zero", 4'b0000, M_IN, 4'b0000, 0);
    press_exp("lvl0_onehot", 4'b0100, M_PLAY, 4'b0100, 0);
    pattern = 4'b0000;
    tick();
    push_exp("play_shows_mem", M_PLAY, 4'b0100, 0);
    pop_check();

    // 2/3: level 1, wrong repeat leads to DONE
    do_reset(1'b1);
    press_exp("l1_enter", 4'b1010, M_PLAY, 4'b1010, 0);
    pattern = 4'b0000;
    tick();
    push_exp("l1_play_sw0", M_PLAY, 4'b1010, 0);
    pop_check();
    press_exp("l1_to_rep", 4'b1110, M_REP, 4'b1110, 0);
    press_exp("l1_mismatch", 4'b1110, M_DONE, 4'b1010, 0);
    press_exp("done_wrap1", 4'b1110, M_DONE, 4'b1010, 0);
    press_exp("done_wrap2", 4'b0001, M_DONE, 4'b1010, 0);

    // 4/5: grow to a full memory and reach WIN
    do_reset(1'b1);
    do_round("r1", 4'b0001);
    do_round("r2", 4'b0100);
    do_round("r3", 4'b1000);
    do_round("r4", 4'b0010);
    press_exp("win_step1", 4'b0000, M_WIN, 4'b0100, 4);
    press_exp("win_step2", 4'b0000, M_WIN, 4'b1000, 4);
    press_exp("win_step3", 4'b0000, M_WIN, 4'b0010, 4);
    press_exp("win_wrap", 4'b0000, M_WIN, 4'b0001, 4);

    // 6a: reset from PLAYBACK with press held through release
    do_reset(1'b1);
    press_exp("r6_enter", 4'b0001, M_PLAY, 4'b0001, 0);
    press = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    push_exp("rst_from_play_held", M_IN, 4'b0001, 0);
    pop_check();
    press = 1'b0;
    tick();
    push_exp("rst_from_play_rel", M_IN, 4'b0001, 0);
    pop_check();

    // 6b: reset from REPEAT after a scored round
    seq_len   = 0;
    exp_score = '0;
    do_round("r6b", 4'b0001);
    press_exp("r6b_enter2", 4'b1000, M_PLAY, 4'b0001, 1);
    press_exp("r6b_play2", 4'b1000, M_PLAY, 4'b1000, 1);
    press_exp("r6b_to_rep", 4'b0001, M_REP, 4'b0001, 1);
    press = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    push_exp("rst_from_rep_held", M_IN, 4'b0001, 0);
    pop_check();
    press = 1'b0;
    tick();

    // held button yields one event only
    pattern = 4'b0010;
    press   = 1'b1;
    tick();
    tick();
    tick();
    push_exp("held_one_event", M_PLAY, 4'b0010, 0);
    pop_check();
    press = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
